// File: rtl/tlb_victim_ctrl_pkg.sv
// tlb_victim_ctrl_pkg: shared BIU types and constants for the TLB replacement controller
package tlb_victim_ctrl_pkg;
   typedef logic [1:0] id_t;
   typedef logic [1:0] state_t;
   localparam int DEF_CNT_W = 12;
   localparam int DEF_INIT_CNT = 1;
   localparam state_t S_IDLE = 2'd0;
   localparam state_t S_SEL = 2'd1;
   localparam state_t S_ACK = 2'd2;
   localparam logic [11:0] AGE_CNT = 12'h800;
   localparam logic [11:0] SAT_CNT = 12'hFFF;
endpackage

// File: rtl/tlb_victim_cell.sv
// tlb_victim_cell: two-input victim compare cell (invalid, then non-global, then lower count, then lower id)
module tlb_victim_cell
   import tlb_victim_ctrl_pkg::*;
#(
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic [1:0]       a_id_i,
   input  logic             a_v_i,
   input  logic             a_g_i,
   input  logic [CNT_W-1:0] a_cnt_i,
   input  logic [1:0]       b_id_i,
   input  logic             b_v_i,
   input  logic             b_g_i,
   input  logic [CNT_W-1:0] b_cnt_i,
   output logic [1:0]       y_id_o,
   output logic             y_v_o,
   output logic             y_g_o,
   output logic [CNT_W-1:0] y_cnt_o
);
   logic pick_b;
   // choose the better victim of the two inputs and forward all of its fields
   always_comb begin
      pick_b = (a_v_i != b_v_i) ? !b_v_i :
               !a_v_i ? (b_id_i < a_id_i) :
               (a_g_i != b_g_i) ? !b_g_i :
               (b_cnt_i < a_cnt_i) || (b_cnt_i == a_cnt_i && b_id_i < a_id_i);
      y_id_o  = pick_b ? b_id_i : a_id_i;
      y_v_o   = pick_b ? b_v_i : a_v_i;
      y_g_o   = pick_b ? b_g_i : a_g_i;
      y_cnt_o = pick_b ? b_cnt_i : a_cnt_i;
   end
endmodule

// File: rtl/tlb_victim_ctrl.sv
// tlb_victim_ctrl: per-entry valid/G/counter bookkeeping and refill arbitration for a 4-entry TLB
module tlb_victim_ctrl
   import tlb_victim_ctrl_pkg::*;
#(
   parameter int CNT_W = DEF_CNT_W,
   parameter int INIT_CNT = DEF_INIT_CNT
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       hit_valid,
   input  logic [1:0] hit_id,
   input  logic       refill_req,
   input  logic       refill_g,
   output logic       refill_ack,
   output logic [1:0] refill_id,
   input  logic       flush_all,
   input  logic       flush_nonglobal,
   output logic [3:0] entry_valid,
   output logic [3:0] entry_global,
   output logic       busy
);
   localparam logic [CNT_W-1:0] SAT  = CNT_W'(SAT_CNT);
   localparam logic [CNT_W-1:0] AGE  = CNT_W'(AGE_CNT);
   localparam logic [CNT_W-1:0] INIT = CNT_W'(INIT_CNT);
   localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

   state_t           state_q, state_d;
   id_t              victim_q, victim_d;
   logic [3:0]       valid_q, valid_d, glob_q, glob_d;
   logic [CNT_W-1:0] cnt_q [4];
   logic [CNT_W-1:0] cnt_d [4];
   logic [3:0]       clr, wr;
   logic             ack, hit_ok, age;

   // tree nodes: 0-3 are the entries, 4-5 the leaf-pair winners, 6 the overall victim
   id_t              n_id  [7];
   logic             n_v   [7];
   logic             n_g   [7];
   logic [CNT_W-1:0] n_cnt [7];

   for (genvar i = 0; i < 4; i++) begin : g_leaf
      assign n_id[i]  = id_t'(i);
      assign n_v[i]   = valid_q[i];
      assign n_g[i]   = glob_q[i];
      assign n_cnt[i] = cnt_q[i];
   end

   for (genvar k = 0; k < 3; k++) begin : g_cell
      tlb_victim_cell #(.CNT_W(CNT_W)) u_cell (
         .a_id_i (n_id[2*k]),   .a_v_i (n_v[2*k]),   .a_g_i (n_g[2*k]),   .a_cnt_i (n_cnt[2*k]),
         .b_id_i (n_id[2*k+1]), .b_v_i (n_v[2*k+1]), .b_g_i (n_g[2*k+1]), .b_cnt_i (n_cnt[2*k+1]),
         .y_id_o (n_id[4+k]),   .y_v_o (n_v[4+k]),   .y_g_o (n_g[4+k]),   .y_cnt_o (n_cnt[4+k])
      );
   end

   // next state: refill write beats flush, flush beats hit on the same entry
   always_comb begin
      ack      = state_q == S_ACK;
      clr      = flush_all ? 4'hF : flush_nonglobal ? ~glob_q : 4'h0;
      wr       = ack ? 4'(4'b0001 << victim_q) : 4'h0;
      hit_ok   = hit_valid && valid_q[hit_id] && !clr[hit_id] && !wr[hit_id];
      age      = hit_ok && cnt_q[hit_id] == SAT;
      valid_d  = (valid_q & ~clr) | wr;
      glob_d   = (glob_q & ~wr) | (refill_g ? wr : 4'h0);
      for (int i = 0; i < 4; i++)
         cnt_d[i] = wr[i] ? INIT :
                    (hit_ok && hit_id == id_t'(i)) ? (age ? AGE : cnt_q[i] + ONE) :
                    age ? cnt_q[i] >> 1 : cnt_q[i];
      state_d  = state_q == S_IDLE ? (refill_req ? S_SEL : S_IDLE) :
                 state_q == S_SEL ? ((flush_all || flush_nonglobal) ? S_IDLE : S_ACK) : S_IDLE;
      victim_d = state_q == S_SEL ? n_id[6] : victim_q;
   end

   // state registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         victim_q <= '0;
         valid_q  <= '0;
         glob_q   <= '0;
         cnt_q    <= '{default: '0};
      end else begin
         state_q  <= state_d;
         victim_q <= victim_d;
         valid_q  <= valid_d;
         glob_q   <= glob_d;
         cnt_q    <= cnt_d;
      end
   end

   assign refill_ack   = state_q == S_ACK;
   assign refill_id    = victim_q;
   assign entry_valid  = valid_q;
   assign entry_global = glob_q;
   assign busy         = state_q != S_IDLE;
endmodule

// File: tb/tb_tlb_victim_ctrl.sv
// tb_tlb_victim_ctrl: table vectors, directed corner sequences and random traffic against a reference model
module tb_tlb_victim_ctrl;
   logic       clk = 0;
   logic       rst_n = 0;
   logic       hit_valid = 0;
   logic [1:0] hit_id = 0;
   logic       refill_req = 0;
   logic       refill_g = 0;
   logic       flush_all = 0;
   logic       flush_nonglobal = 0;
   logic       refill_ack;
   logic [1:0] refill_id;
   logic [3:0] entry_valid, entry_global;
   logic       busy;

   int checks = 0;
   int errors = 0;

   // reference model: per-entry state, refill phase (0 idle, 1 selecting, 2 acking) and chosen victim
   int mv [4];
   int mg [4];
   int mc [4];
   int mph;
   int mvict;

   tlb_victim_ctrl dut (
      .clk(clk), .rst_n(rst_n), .hit_valid(hit_valid), .hit_id(hit_id),
      .refill_req(refill_req), .refill_g(refill_g), .refill_ack(refill_ack), .refill_id(refill_id),
      .flush_all(flush_all), .flush_nonglobal(flush_nonglobal),
      .entry_valid(entry_valid), .entry_global(entry_global), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit req, g, hv; bit [1:0] hid; bit fa, fn;
      bit ack; bit [1:0] id; bit [3:0] v, gl; bit busy;
   } vec_t;
   vec_t tbl [19];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s got=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int pack4(input int a [4]);
      return (a[3] << 3) | (a[2] << 2) | (a[1] << 1) | a[0];
   endfunction

   // victim = entry with the smallest (class, count, id) key; invalid entries rank first by id only
   function automatic int pick();
      int best = 0, bk = 1 << 30, k;
      for (int i = 0; i < 4; i++) begin
         k = mv[i] ? ((1 + mg[i]) << 14) + (mc[i] << 2) + i : i;
         if (k < bk) begin bk = k; best = i; end
      end
      return best;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 4; i++) begin mv[i] = 0; mg[i] = 0; mc[i] = 0; end
      mph = 0; mvict = 0;
   endtask

   task automatic model_clk();
      int nv [4]; int ng [4]; int nc [4];
      bit ackc, hok, age, fl;
      ackc = mph == 2;
      fl = flush_all || (flush_nonglobal && !mg[hit_id]);
      hok = hit_valid && mv[hit_id] != 0 && !fl && !(ackc && mvict == int'(hit_id));
      age = hok && mc[hit_id] == 4095;
      for (int i = 0; i < 4; i++) begin
         nv[i] = (flush_all || (flush_nonglobal && !mg[i])) ? 0 : mv[i];
         ng[i] = mg[i];
         nc[i] = age ? mc[i] / 2 : mc[i];
      end
      if (hok) nc[hit_id] = age ? 2048 : mc[hit_id] + 1;
      if (ackc) begin nv[mvict] = 1; ng[mvict] = refill_g; nc[mvict] = 1; end
      if (mph == 0) mph = refill_req ? 1 : 0;
      else if (mph == 1) begin mvict = pick(); mph = (flush_all || flush_nonglobal) ? 0 : 2; end
      else mph = 0;
      mv = nv; mg = ng; mc = nc;
   endtask

   task automatic check_now();
      @(negedge clk);
      chk("refill_ack", refill_ack, mph == 2);
      chk("entry_valid", entry_valid, pack4(mv));
      chk("entry_global", entry_global, pack4(mg));
      chk("busy", busy, mph != 0);
      if (mph == 2) chk("refill_id", refill_id, mvict);
   endtask

   task automatic tick();
      @(posedge clk);
      model_clk();
      #1;
   endtask

   task automatic step();
      check_now();
      tick();
   endtask

   task automatic refill(input bit g, input int exp_id);
      refill_req = 1; refill_g = g;
      step(); step();
      check_now();
      chk("dir_ack", refill_ack, 1);
      chk("dir_id", refill_id, exp_id);
      tick();
      refill_req = 0;
   endtask

   task automatic hits(input int id, input int n);
      hit_valid = 1; hit_id = 2'(id);
      repeat (n) step();
      hit_valid = 0;
   endtask

   task automatic pulse_flush(input bit all);
      flush_all = all; flush_nonglobal = !all;
      step();
      flush_all = 0; flush_nonglobal = 0;
   endtask

   initial begin
      bit last_ack;
      tbl[0]  = '{1,0,0,0,0,0, 0,0,4'b0000,4'b0000,0};
      tbl[1]  = '{1,0,0,0,0,0, 0,0,4'b0000,4'b0000,1};
      tbl[2]  = '{1,0,0,0,0,0, 1,0,4'b0000,4'b0000,1};
      tbl[3]  = '{1,0,0,0,0,0, 0,0,4'b0001,4'b0000,0};
      tbl[4]  = '{1,0,0,0,0,0, 0,0,4'b0001,4'b0000,1};
      tbl[5]  = '{1,0,0,0,0,0, 1,1,4'b0001,4'b0000,1};
      tbl[6]  = '{1,0,0,0,0,0, 0,0,4'b0011,4'b0000,0};
      tbl[7]  = '{1,0,0,0,0,0, 0,0,4'b0011,4'b0000,1};
      tbl[8]  = '{1,0,0,0,0,0, 1,2,4'b0011,4'b0000,1};
      tbl[9]  = '{1,0,0,0,0,0, 0,0,4'b0111,4'b0000,0};
      tbl[10] = '{1,0,0,0,0,0, 0,0,4'b0111,4'b0000,1};
      tbl[11] = '{1,0,0,0,0,0, 1,3,4'b0111,4'b0000,1};
      tbl[12] = '{0,0,1,0,0,0, 0,0,4'b1111,4'b0000,0};
      tbl[13] = '{0,0,1,1,0,0, 0,0,4'b1111,4'b0000,0};
      tbl[14] = '{0,0,1,3,0,0, 0,0,4'b1111,4'b0000,0};
      tbl[15] = '{1,0,0,0,0,0, 0,0,4'b1111,4'b0000,0};
      tbl[16] = '{1,0,0,0,0,0, 0,0,4'b1111,4'b0000,1};
      tbl[17] = '{1,0,0,0,0,0, 1,2,4'b1111,4'b0000,1};
      tbl[18] = '{0,0,0,0,0,0, 0,0,4'b1111,4'b0000,0};

      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ack", refill_ack, 0);
      chk("rst_id", refill_id, 0);
      chk("rst_valid", entry_valid, 0);
      chk("rst_global", entry_global, 0);
      chk("rst_busy", busy, 0);
      @(negedge clk) rst_n = 1;
      @(posedge clk);
      #1;

      // first refill, fill-up and lowest-count victim
      for (int r = 0; r < 19; r++) begin
         refill_req = tbl[r].req; refill_g = tbl[r].g; hit_valid = tbl[r].hv; hit_id = tbl[r].hid;
         flush_all = tbl[r].fa; flush_nonglobal = tbl[r].fn;
         check_now();
         chk($sformatf("tbl%0d_ack", r), refill_ack, tbl[r].ack);
         if (tbl[r].ack) chk($sformatf("tbl%0d_id", r), refill_id, tbl[r].id);
         chk($sformatf("tbl%0d_valid", r), entry_valid, tbl[r].v);
         chk($sformatf("tbl%0d_global", r), entry_global, tbl[r].gl);
         chk($sformatf("tbl%0d_busy", r), busy, tbl[r].busy);
         tick();
      end
      refill_req = 0; hit_valid = 0;

      // a single non-global entry wins even with the highest count
      pulse_flush(1);
      refill(1, 0); refill(1, 1); refill(1, 2); refill(0, 3);
      hits(3, 5);
      refill(0, 3);

      // flush_nonglobal keeps global entries; flush during SEL aborts and re-arbitrates
      pulse_flush(1);
      refill(1, 0); refill(0, 1); refill(1, 2); refill(0, 3);
      pulse_flush(0);
      check_now();
      chk("fng_valid", entry_valid, 4'b0101);
      tick();
      refill_req = 1;
      step();
      flush_all = 1;
      check_now();
      chk("sel_busy", busy, 1);
      tick();
      flush_all = 0;
      check_now();
      chk("abort_ack", refill_ack, 0);
      chk("abort_busy", busy, 0);
      tick();
      step();
      check_now();
      chk("rerun_ack", refill_ack, 1);
      chk("rerun_id", refill_id, 0);
      tick();
      refill_req = 0;

      // saturation ages all counters: cnt0 16->8 so entry 0 loses to two entries at 9
      pulse_flush(1);
      refill(0, 0); refill(0, 1); refill(0, 2); refill(0, 3);
      hits(1, 4094);
      hits(0, 15);
      hits(1, 1);
      hits(2, 9);
      hits(3, 9);
      refill(0, 0);

      // random traffic with a protocol-respecting walker
      last_ack = 0;
      for (int c = 0; c < 3000; c++) begin
         if (last_ack) refill_req = 1'($urandom_range(0, 1));
         else if (!refill_req) refill_req = $urandom_range(0, 3) == 0;
         refill_g = 1'($urandom_range(0, 1));
         hit_valid = 1'($urandom_range(0, 1));
         hit_id = 2'($urandom_range(0, 3));
         flush_all = $urandom_range(0, 40) == 0;
         flush_nonglobal = $urandom_range(0, 25) == 0;
         last_ack = mph == 2;
         step();
      end
      refill_req = 0; hit_valid = 0; flush_all = 0; flush_nonglobal = 0;
      repeat (3) step();

      // reset in the ACK cycle suppresses the ack and clears everything at once
      refill_req = 1;
      step(); step();
      chk("pre_rst_busy", busy, 1);
      #2 rst_n = 0;
      #1;
      chk("midrst_ack", refill_ack, 0);
      chk("midrst_id", refill_id, 0);
      chk("midrst_valid", entry_valid, 0);
      chk("midrst_global", entry_global, 0);
      chk("midrst_busy", busy, 0);
      refill_req = 0;
      model_reset();
      @(negedge clk) rst_n = 1;
      @(posedge clk);
      #1;
      repeat (2) step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
